// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data access.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP and returns a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    input  logic          hlt,
    output logic          if_rdy,
    output logic [DW-1:0] if_rdata,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rdy,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          busy,
    output logic          err
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic          own_data_q, own_data_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          if_rdy_q, if_rdy_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          d_rdy_q, d_rdy_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_rdy_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdy_q    <= 1'b0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q    <= state_d;
            own_data_q <= own_data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_rdy_q   <= if_rdy_d;
            if_rdata_q <= if_rdata_d;
            d_rdy_q    <= d_rdy_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        own_data_d = own_data_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_rdy_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdy_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;

        if (state_q != S_IDLE && !own_data_q && if_flush) begin
            flush_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                flush_d = 1'b0;
                if (d_re || d_we) begin
                    own_data_d = 1'b1;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    mem_en_d   = 1'b1;
                    mem_we_d   = d_we;
                    state_d    = S_ISSUE;
                    if (d_re && d_we) begin
                        err_d = 1'b1;
                    end
                end else if (if_req && !hlt && !if_flush) begin
                    own_data_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    mem_en_d   = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (own_data_q) begin
                        d_rdy_d   = 1'b1;
                        d_rdata_d = we_q ? '0 : mem_rdata;
                    end else if (!(flush_q || if_flush)) begin
                        // A redirect seen this cycle still kills the stale fetch response.
                        if_rdy_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdy    = if_rdy_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdy     = d_rdy_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

    // Gated by rst_n so the stall is also low while reset is held.
    assign stall = rst_n & ((((d_re | d_we) & ~d_rdy_q)) | (if_req & ~if_rdy_q & ~hlt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner sequences and
// random transactions checked against a memory reference model and fixed-latency timing rules.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int AW      = 16;
    localparam int DW      = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          hlt = 1'b0;
    logic          if_rdy;
    logic [DW-1:0] if_rdata;
    logic          d_re = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rdy;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [DW-1:0] last_if = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .hlt(hlt),
        .if_rdy(if_rdy), .if_rdata(if_rdata),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall(stall), .busy(busy), .err(err)
    );

    // Memory macro model: contents written by DUT strobes, read data valid MEM_LAT cycles later.
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    // Reference contents the bench expects, updated from the transactions it requests.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;
    rd_t rd_q[$];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] macro_rd(input logic [AW-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            rd_q.push_back('{cyc + MEM_LAT, macro_rd(mem_addr)});
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
        if (rd_q.size() > 0 && rd_q[0].due == cyc) mem_rdata = rd_q[0].data;
        else mem_rdata = DW'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // kind: 0 fetch, 1 read, 2 write, 3 read+write together (handled as a write)
    task automatic do_txn(input string tag, input int kind, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_d);
        logic is_wr;
        is_wr = (kind >= 2);
        tick();
        if_req  = (kind == 0);
        if_addr = a;
        d_re    = (kind == 1 || kind == 3);
        d_we    = is_wr;
        d_addr  = a;
        d_wdata = wd;
        @(negedge clk);
        check({tag, " grant"}, {busy, stall}, 2'b01);
        tick();
        if_addr = AW'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
        @(negedge clk);
        check({tag, " issue"}, {mem_en, mem_we, mem_addr}, {1'b1, is_wr, a});
        if (is_wr) begin
            check({tag, " wdata"}, mem_wdata, wd);
            ref_mem[a] = wd;
        end
        repeat (MEM_LAT) begin
            tick();
            @(negedge clk);
            check({tag, " wait"}, {mem_en, if_rdy, d_rdy, stall}, 4'b0001);
        end
        tick();
        @(negedge clk);
        if (kind == 0) begin
            check({tag, " if resp"}, {if_rdy, d_rdy, stall, if_rdata}, {3'b100, exp_d});
            last_if = exp_d;
        end else begin
            check({tag, " d resp"}, {if_rdy, d_rdy, stall, d_rdata}, {3'b010, exp_d});
        end
        tick();
        if_req = 1'b0;
        d_re   = 1'b0;
        d_we   = 1'b0;
        @(negedge clk);
        check({tag, " idle"}, {busy, if_rdy, d_rdy}, 3'b000);
    endtask

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 16'h0010, 16'h0000, 16'hA5A5};
        vecs[1] = '{2, 16'h0200, 16'hBEEF, 16'h0000};
        vecs[2] = '{1, 16'h0200, 16'h0000, 16'hBEEF};
        vecs[3] = '{1, 16'h0100, 16'h0000, 16'h1234};
        vecs[4] = '{0, 16'h0200, 16'h0000, 16'hBEEF};
        vecs[5] = '{2, 16'h0010, 16'h0F0F, 16'h0000};
        vecs[6] = '{0, 16'h0010, 16'h0000, 16'h0F0F};
        mem_arr[16'h0010] = 16'hA5A5;
        ref_mem[16'h0010] = 16'hA5A5;
        mem_arr[16'h0100] = 16'h1234;
        ref_mem[16'h0100] = 16'h1234;

        repeat (3) @(negedge clk);
        check("reset mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        check("reset resp", {if_rdy, d_rdy, if_rdata, d_rdata, busy, err, stall}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) do_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr,
                                 vecs[i].wdata, vecs[i].exp_data);
        check("vec err", err, 1'b0);

        // Fetch and data request together: data first, fetch re-arbitrated after RESP.
        for (int k = 0; k < 11; k++) begin
            tick();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 16'h0040;
                d_re = 1'b1;   d_addr = 16'h0100;
            end
            if (k == 5) d_re = 1'b0;
            if (k == 10) if_req = 1'b0;
            @(negedge clk);
            check($sformatf("both k%0d", k), {mem_en, d_rdy, if_rdy, stall},
                  {(k == 1 || k == 6), (k == 4), (k == 9), (k < 9)});
            if (k == 4) check("both d_rdata", d_rdata, 16'h1234);
            if (k == 6) check("both fetch addr", mem_addr, 16'h0040);
            if (k == 9) begin
                check("both if_rdata", if_rdata, ref_rd(16'h0040));
                last_if = ref_rd(16'h0040);
            end
        end

        // Flush during WAIT: memory cycle completes, fetch response dropped.
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0050; end
            if (k == 2) begin if_flush = 1'b1; if_req = 1'b0; end
            if (k == 3) if_flush = 1'b0;
            @(negedge clk);
            check($sformatf("flush k%0d", k), {mem_en, if_rdy, busy},
                  {(k == 1), 1'b0, (k >= 1 && k <= 4)});
            if (k >= 4) check("flush rdata hold", if_rdata, last_if);
        end

        // Halt blocks fetch grants and the fetch stall term; data still served.
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0060; end
            @(negedge clk);
            check($sformatf("hlt k%0d", k), {mem_en, busy, stall}, 3'b000);
        end
        do_txn("hlt read", 1, 16'h0100, 16'h0000, 16'h1234);
        hlt = 1'b0;

        check("err before", err, 1'b0);
        do_txn("re+we", 3, 16'h0310, 16'hC0DE, 16'h0000);
        check("err set", err, 1'b1);
        do_txn("re+we readback", 1, 16'h0310, 16'h0000, 16'hC0DE);
        check("err sticky", err, 1'b1);

        // Reset asserted during WAIT drops the access.
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin d_re = 1'b1; d_addr = 16'h0100; end
        end
        #1 rst_n = 1'b0;
        d_re = 1'b0;
        #1;
        check("rst mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        check("rst resp", {if_rdy, d_rdy, if_rdata, d_rdata, busy, err, stall}, 64'd0);
        last_if = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            check($sformatf("post rst k%0d", k), {if_rdy, d_rdy, busy, mem_en}, 4'b0000);
        end
        do_txn("post rst read", 1, 16'h0100, 16'h0000, 16'h1234);

        // Random transactions against the reference memory.
        for (int n = 0; n < 40; n++) begin
            int            kind;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            kind = int'($urandom_range(0, 2));
            a    = 16'h0300 + AW'($urandom_range(0, 7));
            wd   = DW'($urandom);
            do_txn($sformatf("rnd%0d", n), kind, a, wd, (kind == 2) ? '0 : ref_rd(a));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
